// File: rtl/spi_ram_burst.sv
// spi_ram_burst: parametrised RAM slave behind the SPI parallel side with burst auto-increment.
// Define SPI_RAM_BURST_SVA_EN to compile in the built-in assertions and covers.
module spi_ram_burst #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int AUTO_INC = 1,
   localparam int PW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PW+1:0]         din,
   input  logic                  rx_valid,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  tx_valid,
   output logic                  addr_err
);
   typedef enum logic [1:0] {WR_ADDR, WR_DATA, RD_ADDR, RD_DATA} cmd_t;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);
   cmd_t cmd;
   logic [ADDR_WIDTH-1:0] pa, addr_w, addr_r, w_inc, r_inc;
   logic [DATA_WIDTH-1:0] pd;
   logic oor, inc;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   assign cmd = cmd_t'(din[PW+1:PW]);
   assign pa = din[ADDR_WIDTH-1:0];
   assign pd = din[DATA_WIDTH-1:0];
   assign oor = {1'b0, pa} >= DEPTH;
   assign inc = AUTO_INC != 0;
   // Increments wrap at MEM_DEPTH-1 so an out-of-range address is never generated.
   always_comb begin
      w_inc = (addr_w == LAST) ? '0 : addr_w + ADDR_WIDTH'(1);
      r_inc = (addr_r == LAST) ? '0 : addr_r + ADDR_WIDTH'(1);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
         tx_valid <= 1'b0;
         addr_err <= 1'b0;
         addr_w <= '0;
         addr_r <= '0;
      end else begin
         tx_valid <= rx_valid && cmd == RD_DATA;
         addr_err <= rx_valid && (cmd == WR_ADDR || cmd == RD_ADDR) && oor;
         if (rx_valid && cmd == WR_ADDR && !oor) addr_w <= pa;
         if (rx_valid && cmd == WR_DATA && inc) addr_w <= w_inc;
         if (rx_valid && cmd == RD_ADDR && !oor) addr_r <= pa;
         if (rx_valid && cmd == RD_DATA) begin
            dout <= mem[addr_r];
            if (inc) addr_r <= r_inc;
         end
      end
   end
   // Memory has no reset; a write coinciding with reset is dropped.
   always_ff @(posedge clk)
      if (rst_n && rx_valid && cmd == WR_DATA) mem[addr_w] <= pd;
`ifdef SPI_RAM_BURST_SVA_EN
   logic [DATA_WIDTH-1:0] rd_word;
   assign rd_word = mem[addr_r];
   a_reset: assert property (@(posedge clk) !rst_n |=> dout == '0 && !tx_valid);
   a_write: assert property (@(posedge clk) disable iff (!rst_n)
      rx_valid && cmd == WR_ADDR ##1 rx_valid && cmd == WR_DATA |=> mem[$past(addr_w)] == $past(pd));
   a_txv: assert property (@(posedge clk) disable iff (!rst_n)
      rx_valid && cmd == RD_DATA |=> tx_valid);
   a_read: assert property (@(posedge clk) disable iff (!rst_n)
      rx_valid && cmd == RD_ADDR ##1 rx_valid && cmd == RD_DATA |=> dout == $past(rd_word));
   a_wrap: assert property (@(posedge clk) disable iff (!rst_n)
      inc && rx_valid && cmd == WR_DATA && addr_w == LAST |=> addr_w == '0);
   a_err: assert property (@(posedge clk) disable iff (!rst_n)
      addr_err |-> $past(rx_valid && (cmd == WR_ADDR || cmd == RD_ADDR) && oor));
   c_wrap: cover property (@(posedge clk) disable iff (!rst_n)
      inc && rx_valid && cmd == WR_DATA && addr_w == LAST ##1 addr_w == '0);
   c_err: cover property (@(posedge clk) disable iff (!rst_n) addr_err);
`endif
endmodule
